// File: rtl/flash_op_seq_if.sv
// Flash macro request/ack port between the op sequencer and the phy wrapper.
// One request may be outstanding; qualifiers and address are valid with the request.
interface flash_op_seq_if #(
  parameter int AW = 17,
  parameter int DW = 32
);
  logic          flash_req_o;
  logic          flash_rd_o;
  logic          flash_prog_o;
  logic          flash_pg_erase_o;
  logic          flash_bk_erase_o;
  logic [AW-1:0] flash_addr_o;
  logic [DW-1:0] flash_prog_data_o;
  logic          flash_ack_i;
  logic [DW-1:0] flash_rd_data_i;
  logic          flash_err_i;

  modport master (
    output flash_req_o, flash_rd_o, flash_prog_o,
    output flash_pg_erase_o, flash_bk_erase_o,
    output flash_addr_o, flash_prog_data_o,
    input  flash_ack_i, flash_rd_data_i, flash_err_i
  );

  modport slave (
    input  flash_req_o, flash_rd_o, flash_prog_o,
    input  flash_pg_erase_o, flash_bk_erase_o,
    input  flash_addr_o, flash_prog_data_o,
    output flash_ack_i, flash_rd_data_i, flash_err_i
  );
endinterface

// File: rtl/flash_op_seq.sv
// Flash operation sequencer: turns host read/program/erase commands into
// single-outstanding flash macro requests with program/read data streams.
module flash_op_seq #(
  parameter int BANKS          = 2,
  parameter int PAGES_PER_BANK = 256,
  parameter int WORDS_PER_PAGE = 256,
  parameter int DW             = 32,
  localparam int BKW = $clog2(BANKS),
  localparam int PGW = $clog2(PAGES_PER_BANK),
  localparam int WDW = $clog2(WORDS_PER_PAGE),
  localparam int AW  = BKW + PGW + WDW
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           op_start_i,
  input  logic [1:0]     op_i,
  input  logic           erase_type_i,
  input  logic [AW-1:0]  op_addr_i,
  input  logic [WDW-1:0] op_len_i,
  output logic           op_busy_o,
  output logic           op_done_o,
  output logic           op_err_o,
  input  logic [DW-1:0]  prog_data_i,
  input  logic           prog_valid_i,
  output logic           prog_ready_o,
  output logic [DW-1:0]  rd_data_o,
  output logic           rd_valid_o,
  input  logic           rd_ready_i,
  flash_op_seq_if.master flash
);

  localparam int BPW = AW - WDW;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_PG  = 2'd1;
  localparam logic [1:0] OP_ER  = 2'd2;
  localparam logic [1:0] OP_BAD = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RDHOLD,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic           etype_q, etype_d;
  logic [BPW-1:0] bp_q, bp_d;
  logic [WDW-1:0] word_q, word_d;
  logic [WDW-1:0] len_q, len_d;
  logic [WDW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           req_q, req_d;
  logic           gap_q, gap_d;
  logic [DW-1:0]  rdat_q, rdat_d;
  logic [DW-1:0]  pdat_q, pdat_d;

  logic           pend;
  logic           req;
  logic           ack;
  logic           last;
  logic [WDW-1:0] word_nxt;
  logic [AW-1:0]  addr;

  // A program request is offered combinationally while the stream is valid;
  // once it survives a clock edge it is held in req_q/pdat_q until the ack.
  assign pend = (state_q == REQ) && (op_q == OP_PG) &&
                !req_q && !gap_q && prog_valid_i;
  assign req  = req_q | pend;
  assign ack  = req & flash.flash_ack_i;
  assign last = (cnt_q == len_q);

  assign word_nxt = (word_q == WDW'(WORDS_PER_PAGE - 1)) ?
                    '0 : word_q + 1'b1;

  always_comb begin
    addr = {bp_q, word_q};
    if (op_q == OP_ER) begin
      addr[WDW-1:0] = '0;
      if (etype_q) addr[WDW+PGW-1:WDW] = '0;
    end
  end

  assign flash.flash_req_o       = req;
  assign flash.flash_rd_o        = req & (op_q == OP_RD);
  assign flash.flash_prog_o      = req & (op_q == OP_PG);
  assign flash.flash_pg_erase_o  = req & (op_q == OP_ER) & ~etype_q;
  assign flash.flash_bk_erase_o  = req & (op_q == OP_ER) & etype_q;
  assign flash.flash_addr_o      = addr;
  assign flash.flash_prog_data_o = req_q ? pdat_q :
                                   (pend ? prog_data_i : '0);

  assign prog_ready_o = ack & (op_q == OP_PG);
  assign rd_valid_o   = (state_q == RDHOLD);
  assign rd_data_o    = rdat_q;
  assign op_busy_o    = (state_q != IDLE);
  assign op_done_o    = (state_q == DONE);
  assign op_err_o     = (state_q == DONE) & err_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    etype_d = etype_q;
    bp_d    = bp_q;
    word_d  = word_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    req_d   = req_q;
    gap_d   = 1'b0;
    rdat_d  = rdat_q;
    pdat_d  = pdat_q;

    unique case (state_q)
      IDLE: begin
        if (op_start_i) begin
          op_d    = op_i;
          etype_d = erase_type_i;
          bp_d    = op_addr_i[AW-1:WDW];
          word_d  = op_addr_i[WDW-1:0];
          len_d   = op_len_i;
          cnt_d   = '0;
          err_d   = (op_i == OP_BAD);
          req_d   = (op_i == OP_RD) || (op_i == OP_ER);
          state_d = (op_i == OP_BAD) ? DONE : REQ;
        end
      end
      REQ: begin
        if (pend && !ack) begin
          req_d  = 1'b1;
          pdat_d = prog_data_i;
        end
        if (ack) begin
          req_d = 1'b0;
          if (flash.flash_err_i) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (op_q == OP_RD) begin
            rdat_d  = flash.flash_rd_data_i;
            state_d = RDHOLD;
          end else if (op_q == OP_ER || last) begin
            state_d = DONE;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            word_d = word_nxt;
            gap_d  = 1'b1;
          end
        end
      end
      RDHOLD: begin
        if (rd_ready_i) begin
          if (last) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            word_d  = word_nxt;
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      etype_q <= 1'b0;
      bp_q    <= '0;
      word_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      gap_q   <= 1'b0;
      rdat_q  <= '0;
      pdat_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      etype_q <= etype_d;
      bp_q    <= bp_d;
      word_q  <= word_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      gap_q   <= gap_d;
      rdat_q  <= rdat_d;
      pdat_q  <= pdat_d;
    end
  end

endmodule

// File: tb/tb_flash_op_seq.sv
// Directed bench for flash_op_seq with a latency-configurable flash model.
// Each scenario task drives its own command and checks results inline.
module tb_flash_op_seq;
  localparam int AW  = 17;
  localparam int DW  = 32;
  localparam int WDW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           op_start = 1'b0;
  logic [1:0]     op = '0;
  logic           etype = 1'b0;
  logic [AW-1:0]  op_addr = '0;
  logic [WDW-1:0] op_len = '0;
  logic           op_busy, op_done, op_err;
  logic [DW-1:0]  prog_data = '0;
  logic           prog_valid = 1'b0;
  logic           prog_ready;
  logic [DW-1:0]  rd_data;
  logic           rd_valid;
  logic           rd_ready = 1'b1;
  logic           stall = 1'b0;

  flash_op_seq_if #(.AW(AW), .DW(DW)) f ();

  flash_op_seq dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .op_start_i   (op_start),
    .op_i         (op),
    .erase_type_i (etype),
    .op_addr_i    (op_addr),
    .op_len_i     (op_len),
    .op_busy_o    (op_busy),
    .op_done_o    (op_done),
    .op_err_o     (op_err),
    .prog_data_i  (prog_data),
    .prog_valid_i (prog_valid),
    .prog_ready_o (prog_ready),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .rd_ready_i   (rd_ready),
    .flash        (f.master)
  );

  always #5 clk = ~clk;

  wire [5+DW+5+AW+DW-1:0] all_out = {
    op_busy, op_done, op_err, prog_ready, rd_valid, rd_data,
    f.flash_req_o, f.flash_rd_o, f.flash_prog_o,
    f.flash_pg_erase_o, f.flash_bk_erase_o,
    f.flash_addr_o, f.flash_prog_data_o};

  int tests = 0;
  int fails = 0;

  // flash macro model
  int lat = 0;
  int err_at = 0;
  int n_ack = 0;
  int wait_c = 0;

  initial begin
    f.flash_ack_i     = 1'b0;
    f.flash_err_i     = 1'b0;
    f.flash_rd_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      f.flash_ack_i = 1'b0;
      f.flash_err_i = 1'b0;
      if (rst) begin
        wait_c = 0;
      end else if (f.flash_req_o) begin
        if (wait_c >= lat) begin
          n_ack++;
          f.flash_ack_i     = 1'b1;
          f.flash_err_i     = (n_ack == err_at);
          f.flash_rd_data_i = 32'hC0DE_0000 ^ 32'(f.flash_addr_o);
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end else begin
        wait_c = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      rd_ready = stall ? ~rd_ready : 1'b1;
    end
  end

  // monitor
  logic [AW-1:0] addr_log[$];
  logic [3:0]    qual_log[$];
  logic [DW-1:0] data_log[$];
  logic [DW-1:0] rd_log[$];
  int req_cycles = 0;
  int stab_err = 0;
  int pr_cnt = 0;
  int done_cnt = 0;
  logic done_err = 1'b0;

  initial begin
    logic          req_p, rv_p, rr_p;
    logic [AW-1:0] a_p;
    logic [DW-1:0] d_p, rd_p;
    logic [3:0]    q_p, q;
    req_p = 1'b0; rv_p = 1'b0; rr_p = 1'b0;
    a_p = '0; d_p = '0; rd_p = '0; q_p = '0;
    forever begin
      @(negedge clk);
      #1;
      q = {f.flash_rd_o, f.flash_prog_o,
           f.flash_pg_erase_o, f.flash_bk_erase_o};
      if (rst) begin
        req_p = 1'b0;
        rv_p  = 1'b0;
      end else begin
        if (f.flash_req_o) req_cycles++;
        if (f.flash_req_o && req_p &&
            (f.flash_addr_o != a_p ||
             f.flash_prog_data_o != d_p || q != q_p))
          stab_err++;
        if (f.flash_req_o && f.flash_ack_i) begin
          addr_log.push_back(f.flash_addr_o);
          qual_log.push_back(q);
          data_log.push_back(f.flash_prog_data_o);
        end
        if (prog_ready) pr_cnt++;
        if (rd_valid && rv_p && !rr_p && rd_data != rd_p)
          stab_err++;
        if (rd_valid && rd_ready) rd_log.push_back(rd_data);
        if (op_done) begin
          done_cnt++;
          done_err = op_err;
        end
        req_p = f.flash_req_o;
        a_p   = f.flash_addr_o;
        d_p   = f.flash_prog_data_o;
        q_p   = q;
        rv_p  = rd_valid;
        rr_p  = rd_ready;
        rd_p  = rd_data;
      end
    end
  end

  task automatic start_cmd(input logic [1:0] o, input logic et,
                           input logic [AW-1:0] a,
                           input logic [WDW-1:0] l);
    @(negedge clk);
    op_start = 1'b1;
    op       = o;
    etype    = et;
    op_addr  = a;
    op_len   = l;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit to);
    to = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #2;
      if (done_cnt != d0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    prog_data  = 32'hFFFF_FFFF;
    prog_valid = 1'b1;
    #1;
    tests++;
    if (all_out !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%h want=0", all_out);
    end
    @(negedge clk);
    prog_valid = 1'b0;
    prog_data  = '0;
    rst = 1'b0;
    @(negedge clk);
    #2;
    tests++;
    if ({op_busy, f.flash_req_o, op_done} !== 3'b000) begin
      fails++;
      $display("FAIL post_reset_idle got=%b want=000",
               {op_busy, f.flash_req_o, op_done});
    end
  endtask

  task automatic test_read();
    int a0, r0, d0;
    bit to;
    logic [AW-1:0] ea;
    a0 = addr_log.size(); r0 = rd_log.size(); d0 = done_cnt;
    lat = 0; stall = 1'b1;
    start_cmd(2'd0, 1'b0, {1'b0, 8'd3, 8'd250}, 8'd7);
    wait_done(d0, 200, to);
    stall = 1'b0;
    tests++;
    if (to || addr_log.size() - a0 != 8) begin
      fails++;
      $display("FAIL read_reqs got=%0d want=8 timeout=%0d",
               addr_log.size() - a0, to);
    end
    tests++;
    if (rd_log.size() - r0 != 8) begin
      fails++;
      $display("FAIL read_beats got=%0d want=8", rd_log.size() - r0);
    end
    for (int i = 0; i < 8; i++) begin
      ea = {1'b0, 8'd3, 8'(250 + i)};
      if (a0 + i < addr_log.size()) begin
        tests++;
        if (addr_log[a0+i] !== ea || qual_log[a0+i] !== 4'b1000) begin
          fails++;
          $display("FAIL read_addr[%0d] got=%h/%b want=%h/1000",
                   i, addr_log[a0+i], qual_log[a0+i], ea);
        end
      end
      if (r0 + i < rd_log.size()) begin
        tests++;
        if (rd_log[r0+i] !== (32'hC0DE_0000 ^ 32'(ea))) begin
          fails++;
          $display("FAIL read_data[%0d] got=%h want=%h",
                   i, rd_log[r0+i], 32'hC0DE_0000 ^ 32'(ea));
        end
      end
    end
    @(negedge clk);
    #2;
    tests++;
    if (done_cnt - d0 != 1 || done_err !== 1'b0 || op_busy !== 1'b0) begin
      fails++;
      $display("FAIL read_done got=%0d/%b/%b want=1/0/0",
               done_cnt - d0, done_err, op_busy);
    end
  endtask

  task automatic test_program();
    int a0, d0, p0, rc0, s0;
    bit to, lost;
    lost = 1'b0;
    a0 = addr_log.size(); d0 = done_cnt; p0 = pr_cnt;
    rc0 = req_cycles; s0 = stab_err;
    lat = 2;
    start_cmd(2'd1, 1'b0, 17'h11005, 8'd3);
    repeat (5) @(negedge clk);
    tests++;
    if (req_cycles != rc0) begin
      fails++;
      $display("FAIL prog_no_req_wo_valid got=%0d want=0",
               req_cycles - rc0);
    end
    for (int i = 0; i < 4; i++) begin
      bit seen;
      prog_valid = 1'b1;
      prog_data  = 32'hA5A5_0000 + 32'(i);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (f.flash_req_o) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) lost = 1'b1;
      if (i == 2) begin
        @(negedge clk);
        prog_valid = 1'b0;
        prog_data  = 32'hDEAD_BEEF;
      end
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (prog_ready) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) lost = 1'b1;
      @(negedge clk);
    end
    prog_valid = 1'b0;
    wait_done(d0, 50, to);
    tests++;
    if (to || lost || addr_log.size() - a0 != 4) begin
      fails++;
      $display("FAIL prog_reqs got=%0d want=4 timeout=%0d lost=%0d",
               addr_log.size() - a0, to, lost);
    end
    for (int i = 0; i < 4; i++) begin
      if (a0 + i < addr_log.size()) begin
        tests++;
        if (addr_log[a0+i] !== 17'h11005 + 17'(i) ||
            qual_log[a0+i] !== 4'b0100 ||
            data_log[a0+i] !== 32'hA5A5_0000 + 32'(i)) begin
          fails++;
          $display("FAIL prog_word[%0d] got=%h/%b/%h want=%h/0100/%h",
                   i, addr_log[a0+i], qual_log[a0+i], data_log[a0+i],
                   17'h11005 + 17'(i), 32'hA5A5_0000 + 32'(i));
        end
      end
    end
    tests++;
    if (pr_cnt - p0 != 4 || done_cnt - d0 != 1 || done_err !== 1'b0) begin
      fails++;
      $display("FAIL prog_ready_done got=%0d/%0d/%b want=4/1/0",
               pr_cnt - p0, done_cnt - d0, done_err);
    end
    tests++;
    if (stab_err != s0) begin
      fails++;
      $display("FAIL prog_stable got=%0d want=0", stab_err - s0);
    end
  endtask

  task automatic test_erase();
    logic [AW-1:0] ea[2];
    logic [3:0]    eq[2];
    ea[0] = 17'h10000; eq[0] = 4'b0001;
    ea[1] = 17'h13700; eq[1] = 4'b0010;
    lat = 1;
    for (int i = 0; i < 2; i++) begin
      int a0, d0;
      bit to;
      a0 = addr_log.size(); d0 = done_cnt;
      start_cmd(2'd2, (i == 0), 17'h13742, 8'hFF);
      wait_done(d0, 30, to);
      tests++;
      if (to || addr_log.size() - a0 != 1) begin
        fails++;
        $display("FAIL erase%0d_reqs got=%0d want=1 timeout=%0d",
                 i, addr_log.size() - a0, to);
      end else begin
        tests++;
        if (addr_log[a0] !== ea[i] || qual_log[a0] !== eq[i] ||
            done_err !== 1'b0) begin
          fails++;
          $display("FAIL erase%0d got=%h/%b/%b want=%h/%b/0", i,
                   addr_log[a0], qual_log[a0], done_err, ea[i], eq[i]);
        end
      end
    end
  endtask

  task automatic test_read_error();
    int a0, r0, d0;
    bit to;
    a0 = addr_log.size(); r0 = rd_log.size(); d0 = done_cnt;
    lat = 0;
    err_at = n_ack + 3;
    start_cmd(2'd0, 1'b0, 17'h02010, 8'd5);
    wait_done(d0, 100, to);
    repeat (3) @(negedge clk);
    tests++;
    if (to || addr_log.size() - a0 != 3) begin
      fails++;
      $display("FAIL rderr_reqs got=%0d want=3 timeout=%0d",
               addr_log.size() - a0, to);
    end
    tests++;
    if (rd_log.size() - r0 != 2) begin
      fails++;
      $display("FAIL rderr_beats got=%0d want=2", rd_log.size() - r0);
    end
    tests++;
    if (done_cnt - d0 != 1 || done_err !== 1'b1) begin
      fails++;
      $display("FAIL rderr_done got=%0d/%b want=1/1",
               done_cnt - d0, done_err);
    end
    err_at = 0;
    r0 = rd_log.size(); d0 = done_cnt;
    start_cmd(2'd0, 1'b0, 17'h02000, 8'd0);
    wait_done(d0, 30, to);
    tests++;
    if (to || done_err !== 1'b0 || rd_log.size() - r0 != 1) begin
      fails++;
      $display("FAIL err_clear got=%b/%0d want=0/1 timeout=%0d",
               done_err, rd_log.size() - r0, to);
    end
  endtask

  task automatic test_illegal();
    int d0, rc0;
    bit to;
    d0 = done_cnt; rc0 = req_cycles;
    start_cmd(2'd3, 1'b0, 17'h00123, 8'd4);
    wait_done(d0, 2, to);
    tests++;
    if (to || done_err !== 1'b1) begin
      fails++;
      $display("FAIL illegal_done got=%b timeout=%0d want=1/0",
               done_err, to);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (req_cycles != rc0 || op_busy !== 1'b0) begin
      fails++;
      $display("FAIL illegal_noreq got=%0d/%b want=0/0",
               req_cycles - rc0, op_busy);
    end
  endtask

  task automatic test_reset_mid_read();
    int a0, r0, d0;
    bit to;
    lat = 5;
    start_cmd(2'd0, 1'b0, 17'h10500, 8'd3);
    tests++;
    if (f.flash_req_o !== 1'b1) begin
      fails++;
      $display("FAIL midrst_req_up got=%b want=1", f.flash_req_o);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (all_out !== '0) begin
      fails++;
      $display("FAIL midrst_outputs got=%h want=0", all_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    a0 = addr_log.size(); r0 = rd_log.size(); d0 = done_cnt;
    start_cmd(2'd0, 1'b0, 17'h105FF, 8'd1);
    wait_done(d0, 50, to);
    tests++;
    if (to || addr_log.size() - a0 != 2 || rd_log.size() - r0 != 2) begin
      fails++;
      $display("FAIL postrst_read got=%0d/%0d want=2/2 timeout=%0d",
               addr_log.size() - a0, rd_log.size() - r0, to);
    end else begin
      tests++;
      if (addr_log[a0+1] !== 17'h10500 ||
          rd_log[r0+1] !== (32'hC0DE_0000 ^ 32'h0001_0500) ||
          done_err !== 1'b0) begin
        fails++;
        $display("FAIL postrst_wrap got=%h/%h/%b want=10500/%h/0",
                 addr_log[a0+1], rd_log[r0+1], done_err,
                 32'hC0DE_0000 ^ 32'h0001_0500);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_program();
    test_erase();
    test_read_error();
    test_illegal();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
